// File: rtl/mem_subsys_if.sv
// Signal bundle for mem_subsys: CPU data and instruction ports, board I/O and the program loader.
// The slave modport is the memory subsystem; the master modport is whoever drives the CPU and loader side.
interface mem_subsys_if;
  logic [14:0] data_addr;
  logic [15:0] out_m;
  logic        write_m;
  logic [15:0] in_m;
  logic [8:0]  inst_addr;
  logic [31:0] in_inst;
  logic [3:0]  SW;
  logic [7:0]  leds;
  logic        ld_start;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_resetN;

  modport slave (
    input  data_addr, out_m, write_m, inst_addr, SW,
    input  ld_start, ld_valid, ld_data, ld_last,
    output in_m, in_inst, leds, ld_ready, ld_done, cpu_resetN
  );

  modport master (
    output data_addr, out_m, write_m, inst_addr, SW,
    output ld_start, ld_valid, ld_data, ld_last,
    input  in_m, in_inst, leds, ld_ready, ld_done, cpu_resetN
  );
endinterface

// File: rtl/mem_subsys.sv
// Memory subsystem: data RAM plus memory-mapped switches, LEDs and timer, and an instruction RAM
// that the program loader fills one halfword per beat while it holds the CPU in reset.
module mem_subsys #(
  parameter int RAM_WORDS  = 1024,
  parameter int IMEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        resetN,
  mem_subsys_if.slave bus
);
  localparam int          RAM_AW   = $clog2(RAM_WORDS);
  localparam logic [14:0] ADDR_SW  = 15'h6000;
  localparam logic [14:0] ADDR_LED = 15'h6001;
  localparam logic [14:0] ADDR_TLO = 15'h6002;
  localparam logic [14:0] ADDR_THI = 15'h6003;

  typedef enum logic [1:0] {RUN, LOAD, RELEASE} ldState_t;

  ldState_t    r_state;
  ldState_t    w_nextState;
  logic [9:0]  r_hp;
  logic [9:0]  w_nextHp;
  logic        r_ldReady;
  logic        r_ldDone;
  logic        r_cpuResetN;

  logic [15:0] r_ram    [RAM_WORDS];
  logic [15:0] r_imemLo [IMEM_WORDS];
  logic [15:0] r_imemHi [IMEM_WORDS];

  logic [15:0] r_inM;
  logic [31:0] r_inInst;
  logic [3:0]  r_swMeta;
  logic [3:0]  r_swSync;
  logic [7:0]  r_leds;
  logic [31:0] r_timer;
  logic [15:0] r_shadow;

  logic              w_ramHit;
  logic [RAM_AW-1:0] w_ramIdx;
  logic              w_dataWe;
  logic              w_timerClr;
  logic              w_beat;
  logic [15:0]       w_rdData;

  assign w_ramHit   = 32'(bus.data_addr) < RAM_WORDS;
  assign w_ramIdx   = bus.data_addr[RAM_AW-1:0];
  assign w_dataWe   = bus.write_m && r_cpuResetN;
  assign w_timerClr = w_dataWe && (bus.data_addr == ADDR_TLO);
  assign w_beat     = (r_state == LOAD) && bus.ld_valid && r_ldReady;

  always_comb begin
    w_rdData = '0;
    if (w_ramHit) begin
      w_rdData = r_ram[w_ramIdx];
    end else begin
      case (bus.data_addr)
        ADDR_SW:  w_rdData = {12'd0, r_swSync};
        ADDR_LED: w_rdData = {8'd0, r_leds};
        ADDR_TLO: w_rdData = r_timer[15:0];
        ADDR_THI: w_rdData = r_shadow;
        default:  w_rdData = '0;
      endcase
    end
  end

  // Storage arrays are never reset; the registered read ports give read-first behaviour.
  always_ff @(posedge clk) begin
    if (w_dataWe && w_ramHit) begin
      r_ram[w_ramIdx] <= bus.out_m;
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      if (r_hp[0]) begin
        r_imemHi[r_hp[9:1]] <= bus.ld_data;
      end else begin
        r_imemLo[r_hp[9:1]] <= bus.ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_inM    <= '0;
      r_inInst <= '0;
      r_swMeta <= '0;
      r_swSync <= '0;
      r_leds   <= '0;
      r_timer  <= '0;
      r_shadow <= '0;
    end else begin
      r_inM    <= w_rdData;
      r_inInst <= {r_imemHi[bus.inst_addr], r_imemLo[bus.inst_addr]};
      r_swMeta <= bus.SW;
      r_swSync <= r_swMeta;
      if (w_dataWe && (bus.data_addr == ADDR_LED)) begin
        r_leds <= bus.out_m[7:0];
      end
      // Reading the low half latches the high half so a following high read is coherent.
      if (w_timerClr) begin
        r_timer  <= '0;
        r_shadow <= '0;
      end else begin
        r_timer <= r_timer + 32'd1;
        if (bus.data_addr == ADDR_TLO) begin
          r_shadow <= r_timer[31:16];
        end
      end
    end
  end

  // Handshake outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= RUN;
      r_hp        <= '0;
      r_ldReady   <= 1'b0;
      r_ldDone    <= 1'b0;
      r_cpuResetN <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_hp        <= w_nextHp;
      r_ldReady   <= (w_nextState == LOAD);
      r_ldDone    <= (w_nextState == RELEASE);
      r_cpuResetN <= (w_nextState == RUN);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextHp    = r_hp;
    case (r_state)
      RUN: begin
        if (bus.ld_start) begin
          w_nextState = LOAD;
          w_nextHp    = '0;
        end
      end
      LOAD: begin
        if (w_beat) begin
          w_nextHp = r_hp + 10'd1;
          if (bus.ld_last || (r_hp == 10'd1023)) begin
            w_nextState = RELEASE;
          end
        end
      end
      RELEASE: w_nextState = RUN;
      default: w_nextState = RUN;
    endcase
  end

  assign bus.in_m       = r_inM;
  assign bus.in_inst    = r_inInst;
  assign bus.leds       = r_leds;
  assign bus.ld_ready   = r_ldReady;
  assign bus.ld_done    = r_ldDone;
  assign bus.cpu_resetN = r_cpuResetN;
endmodule

// File: tb/tb_mem_subsys.sv
// Self-checking bench for mem_subsys: a behavioural model is compared against the DUT on every
// cycle, alongside hand-computed expectations for the directed scenarios.
module tb_mem_subsys;
  logic clk = 1'b0;
  logic resetN;

  mem_subsys_if bus ();

  mem_subsys #(.RAM_WORDS(1024), .IMEM_WORDS(512)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  localparam int PH_RUN = 0, PH_LOAD = 1, PH_RELEASE = 2;

  bit        mValid = 1'b0;
  bit [15:0] mRam      [1024];
  bit        mRamKnown [1024];
  bit [15:0] mImLo     [512];
  bit [15:0] mImHi     [512];
  bit        mLoKnown  [512];
  bit        mHiKnown  [512];
  int        mPhase;
  int        mHp;
  bit [31:0] mTimer;
  bit [15:0] mShadow;
  bit        mForced = 1'b0;
  bit [3:0]  mSw1, mSw2;
  bit [7:0]  mLeds;
  bit [15:0] eInM;
  bit        eInMKnown;
  bit [31:0] eInst;
  bit        eInstKnown;
  bit        eReady, eDone, eCpuRun;

  logic [15:0] beatVals [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPhase     = PH_RUN;
    mHp        = 0;
    mTimer     = '0;
    mShadow    = '0;
    mSw1       = '0;
    mSw2       = '0;
    mLeds      = '0;
    eInM       = '0;
    eInMKnown  = 1'b1;
    eInst      = '0;
    eInstKnown = 1'b1;
    eReady     = 1'b0;
    eDone      = 1'b0;
    eCpuRun    = 1'b0;
    mValid     = 1'b1;
  endtask

  // One clock edge of the specified behaviour, evaluated from the inputs held before the edge.
  task automatic modelStep();
    int a;
    int w;
    bit we;
    a  = int'(bus.data_addr);
    we = bus.write_m && eCpuRun;

    eInM = '0;
    eInMKnown = 1'b1;
    if (a < 1024) begin
      eInM      = mRam[a];
      eInMKnown = mRamKnown[a];
    end else if (a == 'h6000) eInM = {12'd0, mSw2};
    else if (a == 'h6001) eInM = {8'd0, mLeds};
    else if (a == 'h6002) eInM = mTimer[15:0];
    else if (a == 'h6003) eInM = mShadow;

    w          = int'(bus.inst_addr);
    eInst      = {mImHi[w], mImLo[w]};
    eInstKnown = mLoKnown[w] && mHiKnown[w];

    if (we && a < 1024) begin
      mRam[a]      = bus.out_m;
      mRamKnown[a] = 1'b1;
    end
    if (we && a == 'h6001) mLeds = bus.out_m[7:0];
    if (we && a == 'h6002) begin
      mTimer  = '0;
      mShadow = '0;
    end else begin
      if (a == 'h6002) mShadow = mTimer[31:16];
      if (!mForced) mTimer = mTimer + 32'd1;
    end

    mSw2 = mSw1;
    mSw1 = bus.SW;

    if (mPhase == PH_RUN) begin
      if (bus.ld_start) begin
        mPhase = PH_LOAD;
        mHp    = 0;
      end
    end else if (mPhase == PH_LOAD) begin
      if (bus.ld_valid) begin
        if (mHp % 2 == 0) begin
          mImLo[mHp / 2]    = bus.ld_data;
          mLoKnown[mHp / 2] = 1'b1;
        end else begin
          mImHi[mHp / 2]    = bus.ld_data;
          mHiKnown[mHp / 2] = 1'b1;
        end
        if (bus.ld_last || mHp == 1023) mPhase = PH_RELEASE;
        mHp = (mHp + 1) % 1024;
      end
    end else begin
      mPhase = PH_RUN;
    end

    eReady  = (mPhase == PH_LOAD);
    eDone   = (mPhase == PH_RELEASE);
    eCpuRun = (mPhase == PH_RUN);
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) modelReset();
    else modelStep();
  end

  always @(negedge clk) begin
    if (mValid) begin
      if (eInMKnown) checkOutput("model in_m", 32'(bus.in_m), 32'(eInM));
      if (eInstKnown) checkOutput("model in_inst", bus.in_inst, eInst);
      checkOutput("model leds", 32'(bus.leds), 32'(mLeds));
      checkOutput("model ld_ready", 32'(bus.ld_ready), 32'(eReady));
      checkOutput("model ld_done", 32'(bus.ld_done), 32'(eDone));
      checkOutput("model cpu_resetN", 32'(bus.cpu_resetN), 32'(eCpuRun));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [14:0] addr, input logic [15:0] wdata, input logic we);
    bus.data_addr = addr;
    bus.out_m     = wdata;
    bus.write_m   = we;
    tick();
  endtask

  initial begin
    int beats;
    resetN        = 1'b0;
    bus.data_addr = '0;
    bus.out_m     = '0;
    bus.write_m   = 1'b0;
    bus.inst_addr = '0;
    bus.SW        = '0;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    tick();
    tick();
    checkOutput("reset in_m", 32'(bus.in_m), 32'h0);
    checkOutput("reset in_inst", bus.in_inst, 32'h0);
    checkOutput("reset leds", 32'(bus.leds), 32'h0);
    checkOutput("reset cpu_resetN", 32'(bus.cpu_resetN), 32'h0);
    checkOutput("reset ld_ready", 32'(bus.ld_ready), 32'h0);
    checkOutput("reset ld_done", 32'(bus.ld_done), 32'h0);
    resetN = 1'b1;
    tick();
    checkOutput("cpu_resetN rise", 32'(bus.cpu_resetN), 32'h1);

    applyStimulus(15'h0005, 16'h1234, 1'b1);
    applyStimulus(15'h0005, 16'h0000, 1'b0);
    checkOutput("ram read", 32'(bus.in_m), 32'h1234);
    applyStimulus(15'h0005, 16'hBEEF, 1'b1);
    checkOutput("read-first", 32'(bus.in_m), 32'h1234);
    applyStimulus(15'h0005, 16'h0000, 1'b0);
    checkOutput("ram new data", 32'(bus.in_m), 32'hBEEF);

    bus.SW = 4'b1010;
    repeat (3) applyStimulus(15'h6000, 16'h0000, 1'b0);
    checkOutput("sw read", 32'(bus.in_m), 32'h000A);
    applyStimulus(15'h6001, 16'h01FF, 1'b1);
    checkOutput("leds write", 32'(bus.leds), 32'hFF);
    applyStimulus(15'h6001, 16'h0000, 1'b0);
    checkOutput("leds read", 32'(bus.in_m), 32'h00FF);
    applyStimulus(15'h7FFF, 16'h0000, 1'b0);
    checkOutput("unmapped read", 32'(bus.in_m), 32'h0);

    // Preset the timer just below a high-half carry to exercise the shadow register.
    bus.data_addr = 15'h6002;
    force dut.r_timer = 32'h0001FFFF;
    mTimer  = 32'h0001FFFF;
    mForced = 1'b1;
    tick();
    checkOutput("timer low", 32'(bus.in_m), 32'hFFFF);
    release dut.r_timer;
    mForced = 1'b0;
    bus.data_addr = 15'h6003;
    tick();
    checkOutput("timer shadow", 32'(bus.in_m), 32'h0001);
    applyStimulus(15'h6002, 16'h0000, 1'b1);
    applyStimulus(15'h6002, 16'h0000, 1'b0);
    checkOutput("timer cleared", 32'(bus.in_m <= 16'd1), 32'h1);

    for (int i = 0; i < 300; i++) begin
      int sel;
      logic [14:0] addr;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) addr = 15'($urandom_range(6, 15));
      else if (sel == 6) addr = 15'h6000;
      else if (sel == 7) addr = 15'h6001;
      else if (sel == 8) addr = 15'($urandom_range('h6002, 'h6003));
      else addr = 15'($urandom_range(1024, 'h7FFF));
      bus.SW        = 4'($urandom);
      bus.inst_addr = 9'($urandom_range(0, 3));
      applyStimulus(addr, 16'($urandom), ($urandom_range(0, 3) == 0));
    end

    bus.write_m   = 1'b0;
    bus.data_addr = 15'h0005;
    bus.ld_start  = 1'b1;
    tick();
    checkOutput("load ready", 32'(bus.ld_ready), 32'h1);
    checkOutput("load cpu held", 32'(bus.cpu_resetN), 32'h0);
    bus.ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = beatVals[i];
      bus.ld_last  = (i == 2);
      tick();
    end
    checkOutput("release done", 32'(bus.ld_done), 32'h1);
    checkOutput("release cpu held", 32'(bus.cpu_resetN), 32'h0);
    bus.ld_valid  = 1'b0;
    bus.ld_last   = 1'b0;
    bus.inst_addr = 9'd0;
    tick();
    checkOutput("done one cycle", 32'(bus.ld_done), 32'h0);
    checkOutput("cpu released", 32'(bus.cpu_resetN), 32'h1);
    checkOutput("imem word0", bus.in_inst, 32'hBBBBAAAA);
    bus.inst_addr = 9'd1;
    tick();
    checkOutput("imem word1 low", 32'(bus.in_inst[15:0]), 32'hCCCC);

    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    bus.data_addr = 15'h0005;
    bus.out_m     = 16'hDEAD;
    bus.write_m   = 1'b1;
    beats = 0;
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 16'($urandom);
        tick();
      end
      bus.ld_valid = 1'b1;
      bus.ld_data  = 16'($urandom);
      bus.ld_last  = (b == 5);
      tick();
      beats++;
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    bus.write_m  = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.inst_addr = 9'(i);
      tick();
    end

    bus.ld_start = 1'b1;
    tick();
    bus.ld_start  = 1'b0;
    bus.data_addr = 15'h0005;
    bus.out_m     = 16'hDEAD;
    bus.write_m   = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.ld_valid  = 1'b1;
      bus.ld_data   = 16'($urandom);
      bus.inst_addr = 9'($urandom);
      tick();
      if (i == 1022) checkOutput("full not early", 32'(bus.ld_done), 32'h0);
    end
    checkOutput("full release", 32'(bus.ld_done), 32'h1);
    bus.ld_valid = 1'b0;
    bus.write_m  = 1'b0;
    tick();
    applyStimulus(15'h0005, 16'h0000, 1'b0);
    checkOutput("ram kept during load", 32'(bus.in_m), 32'hBEEF);
    for (int i = 0; i < 16; i++) begin
      bus.inst_addr = (i == 0) ? 9'd511 : 9'($urandom);
      tick();
    end

    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
    bus.inst_addr = 9'd0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'h1111;
    tick();
    bus.ld_data  = 16'h2222;
    tick();
    bus.ld_valid = 1'b0;
    resetN = 1'b0;
    #1;
    checkOutput("abort cpu held", 32'(bus.cpu_resetN), 32'h0);
    checkOutput("abort ready low", 32'(bus.ld_ready), 32'h0);
    tick();
    resetN = 1'b1;
    tick();
    checkOutput("abort cpu rise", 32'(bus.cpu_resetN), 32'h1);
    checkOutput("abort no done", 32'(bus.ld_done), 32'h0);
    tick();
    checkOutput("abort imem kept", bus.in_inst, 32'h22221111);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
